// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// ALU and LSU share the port in round-robin order. A pending-write scoreboard feeds hazard checks in issue.
module rf_wb_arbiter #(
    parameter int NREQ_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [NREQ_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [NREQ_W-1:0]          lsu_rd,
    input  logic [DATA_W-1:0]          lsu_data,
    output logic                       rf_wren,
    output logic [NREQ_W-1:0]          rf_rd_addr,
    output logic [DATA_W-1:0]          rf_wr_data,
    input  logic                       busy_set,
    input  logic [NREQ_W-1:0]          busy_set_addr,
    output logic [(1<<NREQ_W)-1:0]     busy_vec,
    output logic                       busy_err
);

    localparam int NREG = 1 << NREQ_W;

    logic              prefer_alu;
    logic              grant_alu;
    logic              grant_lsu;
    logic              xfer;
    logic [NREQ_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // The output register never stalls, so a grant is always a transfer.
    always_comb begin
        grant_alu = rst && alu_valid && (!lsu_valid || prefer_alu);
        grant_lsu = rst && lsu_valid && (!alu_valid || !prefer_alu);
        xfer      = grant_alu || grant_lsu;
        sel_rd    = grant_lsu ? lsu_rd   : alu_rd;
        sel_data  = grant_lsu ? lsu_data : alu_data;
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prefer_alu <= 1'b1;
        end else if (grant_alu) begin
            prefer_alu <= 1'b0;
        end else if (grant_lsu) begin
            prefer_alu <= 1'b1;
        end
    end

    // Writes to x0 occupy the slot but never assert the write strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wren    <= 1'b1;
            rf_rd_addr <= '0;
            rf_wr_data <= '0;
        end else if (xfer) begin
            rf_wren    <= (sel_rd == '0);
            rf_rd_addr <= sel_rd;
            rf_wr_data <= sel_data;
        end else begin
            rf_wren    <= 1'b1;
        end
    end

    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] busy_nxt;
    logic            set_hit;

    // A set landing on the register being committed this cycle wins and is not an error.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (!rf_wren) clr_mask[rf_rd_addr] = 1'b1;
        if (busy_set && (busy_set_addr != '0)) set_mask[busy_set_addr] = 1'b1;
        set_hit  = |(set_mask & busy_vec & ~clr_mask);
        busy_nxt = (busy_vec & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_vec <= '0;
            busy_err <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            if (set_hit) busy_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter. Each row drives one cycle and states the expected readys.
// Registered outputs come from a reference model through an expected-output queue.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wren;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wr_data;
    logic        busy_set;
    logic [4:0]  busy_set_addr;
    logic [31:0] busy_vec;
    logic        busy_err;

    rf_wb_arbiter #(.NREQ_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wren(rf_wren), .rf_rd_addr(rf_rd_addr), .rf_wr_data(rf_wr_data),
        .busy_set(busy_set), .busy_set_addr(busy_set_addr),
        .busy_vec(busy_vec), .busy_err(busy_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        bs;
        logic [4:0]  baddr;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
    } out_t;

    vec_t  tbl[$];
    out_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;

    logic        m_pref_alu;
    logic [31:0] m_busy;
    logic        m_err;
    out_t        m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                                input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldata, input logic bs, input logic [4:0] baddr,
                                input logic ear, input logic elr);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.bs = bs; v.baddr = baddr; v.exp_ar = ear; v.exp_lr = elr;
        return v;
    endfunction

    // Reference behaviour at one rising edge, given the inputs applied before it.
    task automatic model_edge(input vec_t v);
        logic        ga;
        logic        gl;
        logic [31:0] clr;
        if (!v.rst) begin
            m_pref_alu = 1'b1;
            m_busy     = '0;
            m_err      = 1'b0;
            m_out.wren = 1'b1;
            m_out.addr = '0;
            m_out.data = '0;
        end else begin
            ga  = v.av && (!v.lv || m_pref_alu);
            gl  = v.lv && (!v.av || !m_pref_alu);
            clr = '0;
            if (!m_out.wren) clr[m_out.addr] = 1'b1;
            if (v.bs && v.baddr != 5'd0 && m_busy[v.baddr] && !clr[v.baddr]) m_err = 1'b1;
            m_busy = m_busy & ~clr;
            if (v.bs && v.baddr != 5'd0) m_busy[v.baddr] = 1'b1;
            if (ga) begin
                m_out.wren = (v.ard == 5'd0); m_out.addr = v.ard; m_out.data = v.adata;
                m_pref_alu = 1'b0;
            end else if (gl) begin
                m_out.wren = (v.lrd == 5'd0); m_out.addr = v.lrd; m_out.data = v.ldata;
                m_pref_alu = 1'b1;
            end else begin
                m_out.wren = 1'b1;
            end
        end
        exp_q.push_back(m_out);
    endtask

    task automatic step(input int idx, input vec_t v);
        out_t e;
        rst = v.rst;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
        busy_set = v.bs; busy_set_addr = v.baddr;
        #1;
        chk($sformatf("alu_ready[%0d]", idx), {31'd0, alu_ready}, {31'd0, v.exp_ar});
        chk($sformatf("lsu_ready[%0d]", idx), {31'd0, lsu_ready}, {31'd0, v.exp_lr});
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL queue[%0d]: got empty expected entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("rf_wren[%0d]", idx), {31'd0, rf_wren}, {31'd0, e.wren});
            chk($sformatf("rf_rd_addr[%0d]", idx), {27'd0, rf_rd_addr}, {27'd0, e.addr});
            chk($sformatf("rf_wr_data[%0d]", idx), rf_wr_data, e.data);
        end
        chk($sformatf("busy_vec[%0d]", idx), busy_vec, m_busy);
        chk($sformatf("busy_err[%0d]", idx), {31'd0, busy_err}, {31'd0, m_err});
    endtask

    initial begin
        m_pref_alu = 1'b1; m_busy = '0; m_err = 1'b0;
        m_out.wren = 1'b1; m_out.addr = '0; m_out.data = '0;

        // Reset held with ALU pending, then released: accepted in the release cycle.
        tbl.push_back(mk(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fresh reset, then a 4-cycle tie: ALU, LSU, ALU, LSU.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0, 1));
        // Write to x0: accepted, no strobe.
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Mark r7, commit to it two cycles later, then set during its commit cycle.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 32'h78, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Double set of r9 trips the sticky error; it survives traffic until reset.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
        tbl.push_back(mk(1, 1, 13, 32'hD, 1, 12, 32'hC, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 13, 32'hD, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reset right after accepting a write to r10; next tie goes back to ALU.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0));
        tbl.push_back(mk(1, 1, 10, 32'hAA, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 4, 32'hB, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
